// File: rtl/cache_pkg.sv
// cache_pkg: shared state encoding, per-way metadata layout and byte-merge helper for cache_set
package cache_pkg;
  // Widest tag/stamp a way can hold; narrower instances zero-extend into these fields
  localparam int META_TAG_WIDTH = 20;
  localparam int META_TICK_WIDTH = 16;
  typedef enum logic [1:0] {IDLE, EVICT, FILL} cache_set_state_t;
  typedef struct packed {
    logic valid;
    logic dirty;
    logic [META_TAG_WIDTH-1:0] tag;
    logic [META_TICK_WIDTH-1:0] stamp;
  } cache_way_meta_t;
  function automatic logic [31:0] strobe_merge(input logic [31:0] old, input logic [31:0] data,
                                               input logic [3:0] strobe);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (strobe[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/cache_set_way.sv
// cache_way: one way of a set - tag match, strobed store, refill write and metadata update
module cache_way import cache_pkg::*; #(
  parameter int TAG_WIDTH = META_TAG_WIDTH,
  parameter int LINE_WIDTH = 4,
  parameter int TICK_WIDTH = META_TICK_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [TAG_WIDTH-1:0]  tag,
  input  logic [LINE_WIDTH-3:0] word,
  input  logic [TICK_WIDTH-1:0] now,
  input  logic                  touch,
  input  logic                  store,
  input  logic [31:0]           store_data,
  input  logic [3:0]            strobe,
  input  logic                  fill,
  input  logic                  fill_last,
  input  logic [LINE_WIDTH-3:0] fill_word,
  input  logic [31:0]           fill_data,
  output logic                  hit,
  output logic [31:0]           data,
  output cache_way_meta_t       meta
);
  localparam int LINE_SIZE = 2 ** (LINE_WIDTH - 2);
  logic [31:0] mem [LINE_SIZE];
  assign hit = meta.valid && meta.tag == META_TAG_WIDTH'(tag);
  assign data = mem[word];
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      for (int i = 0; i < LINE_SIZE; i++) mem[i] <= '0;
    end else begin
      if (store) mem[word] <= strobe_merge(mem[word], store_data, strobe);
      if (fill) mem[fill_word] <= fill_data;
      if (touch) meta.stamp <= META_TICK_WIDTH'(now);
      if (store) meta.dirty <= 1'b1;
      if (fill && fill_last)
        meta <= '{valid: 1'b1, dirty: 1'b0, tag: META_TAG_WIDTH'(tag), stamp: META_TICK_WIDTH'(now)};
    end
  end
endmodule

// File: rtl/cache_set.sv
// cache_set: N-way set with true-LRU victim choice and a write-back/refill miss engine
module cache_set import cache_pkg::*; #(
  parameter int TAG_WIDTH = META_TAG_WIDTH,
  parameter int LINE_WIDTH = 4,
  parameter int WAYS = 4,
  parameter int TICK_WIDTH = META_TICK_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  input  logic [LINE_WIDTH-1:0] req_index,
  input  logic [31:0]           req_data,
  input  logic [3:0]            req_strobe,
  output logic                  req_ready,
  output logic [31:0]           rdata,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [TAG_WIDTH-1:0]  wb_tag,
  output logic [LINE_WIDTH-3:0] wb_word,
  output logic [31:0]           wb_data,
  output logic                  fill_req,
  input  logic                  fill_valid,
  input  logic [31:0]           fill_data
);
  localparam int WW = LINE_WIDTH - 2;
  localparam int VW = $clog2(WAYS);
  cache_set_state_t state;
  logic [TICK_WIDTH-1:0] now, age, best;
  logic [WW-1:0] cnt, word;
  logic [VW-1:0] victim, vsel, hidx;
  logic [WAYS-1:0] hit;
  logic [31:0] way_data [WAYS];
  cache_way_meta_t meta [WAYS];
  logic idle, found, unused_index;
  assign idle = state == IDLE;
  assign word = state == EVICT ? cnt : req_index[LINE_WIDTH-1:2];
  assign unused_index = ^req_index[1:0];
  for (genvar g = 0; g < WAYS; g++) begin : g_way
    cache_way #(.TAG_WIDTH(TAG_WIDTH), .LINE_WIDTH(LINE_WIDTH), .TICK_WIDTH(TICK_WIDTH)) u_way (
      .clk(clk),
      .reset(reset),
      .tag(req_tag),
      .word(word),
      .now(now),
      .touch(idle && req_valid && hit[g]),
      .store(idle && req_valid && req_write && hit[g]),
      .store_data(req_data),
      .strobe(req_strobe),
      .fill(state == FILL && fill_valid && victim == VW'(g)),
      .fill_last(&cnt),
      .fill_word(cnt),
      .fill_data(fill_data),
      .hit(hit[g]),
      .data(way_data[g]),
      .meta(meta[g])
    );
  end
  // Lowest invalid way first; otherwise oldest by wrapped age, ties to the lowest index
  always_comb begin
    vsel = '0;
    best = '0;
    age = '0;
    found = 1'b0;
    for (int i = 0; i < WAYS; i++)
      if (!found && !meta[i].valid) begin
        vsel = VW'(i);
        found = 1'b1;
      end
    for (int i = 0; i < WAYS; i++) begin
      age = now - TICK_WIDTH'(meta[i].stamp);
      if (!found && age > best) begin
        vsel = VW'(i);
        best = age;
      end
    end
  end
  always_comb begin
    hidx = '0;
    for (int i = WAYS - 1; i >= 0; i--) if (hit[i]) hidx = VW'(i);
  end
  assign req_ready = idle && req_valid && |hit;
  assign rdata = req_ready && !req_write ? way_data[hidx] : '0;
  assign wb_valid = state == EVICT;
  assign fill_req = state == FILL;
  assign wb_word = wb_valid ? cnt : '0;
  assign wb_tag = wb_valid ? TAG_WIDTH'(meta[victim].tag) : '0;
  assign wb_data = wb_valid ? way_data[victim] : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      now <= '0;
      cnt <= '0;
      victim <= '0;
    end else begin
      now <= now + TICK_WIDTH'(1);
      case (state)
        IDLE: if (req_valid && !(|hit)) begin
          victim <= vsel;
          cnt <= '0;
          state <= meta[vsel].valid && meta[vsel].dirty ? EVICT : FILL;
        end
        EVICT: if (wb_ready) begin
          cnt <= cnt + WW'(1);
          if (&cnt) state <= FILL;
        end
        FILL: if (fill_valid) begin
          cnt <= cnt + WW'(1);
          if (&cnt) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_set.sv
// tb_cache_set: directed scoreboard bench for a 2-way, 4-word, 4-bit-tick cache_set
module tb_cache_set;
  logic clk, reset, req_valid, req_write, req_ready, wb_valid, wb_ready, fill_req, fill_valid;
  logic [19:0] req_tag, wb_tag;
  logic [3:0] req_index, req_strobe;
  logic [31:0] req_data, rdata, wb_data, fill_data;
  logic [1:0] wb_word;
  int n_assert = 0, n_fail = 0;
  int nfill, nwb, ncyc;
  logic [31:0] load_q[$], fill_src[$];
  logic [63:0] wb_q[$];

  cache_set #(.TAG_WIDTH(20), .LINE_WIDTH(4), .WAYS(2), .TICK_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write), .req_tag(req_tag),
    .req_index(req_index), .req_data(req_data), .req_strobe(req_strobe), .req_ready(req_ready),
    .rdata(rdata), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_word(wb_word),
    .wb_data(wb_data), .fill_req(fill_req), .fill_valid(fill_valid), .fill_data(fill_data)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1;
    req_valid = 0;
    fill_valid = 0;
    wb_ready = 0;
    fill_src.delete();
    tick;
    reset = 0;
  endtask

  task automatic idle(input int n);
    req_valid = 0;
    repeat (n) tick;
  endtask

  task automatic push_fill(input logic [31:0] a, b, c, d);
    fill_src.push_back(a);
    fill_src.push_back(b);
    fill_src.push_back(c);
    fill_src.push_back(d);
  endtask

  task automatic push_wb(input logic [19:0] t, input logic [31:0] a, b, c, d);
    wb_q.push_back({t, 2'd0, a});
    wb_q.push_back({t, 2'd1, b});
    wb_q.push_back({t, 2'd2, c});
    wb_q.push_back({t, 2'd3, d});
  endtask

  // Holds the request until req_ready, serving write-back and refill beats on the way
  task automatic access(input logic w, input logic [19:0] t, input logic [3:0] idx,
                        input logic [31:0] d, input logic [3:0] s, input int stall);
    int st;
    bit done;
    st = 0;
    done = 0;
    nfill = 0;
    nwb = 0;
    ncyc = 0;
    req_valid = 1; req_write = w; req_tag = t; req_index = idx; req_data = d; req_strobe = s;
    while (!done && ncyc < 200) begin
      fill_valid = fill_req && fill_src.size() > 0;
      fill_data = fill_valid ? fill_src[0] : '0;
      wb_ready = wb_valid && st >= stall;
      @(negedge clk);
      if (wb_valid) begin
        if (wb_q.size() == 0) check("wb_unexpected", wb_valid, 0);
        else if (wb_ready) begin
          check("wb_beat", {wb_tag, wb_word, wb_data}, wb_q.pop_front());
          nwb++;
          st = 0;
        end else begin
          check("wb_stall", {wb_tag, wb_word, wb_data}, wb_q[0]);
          st++;
        end
      end
      if (fill_valid) begin
        void'(fill_src.pop_front());
        nfill++;
      end
      if (req_ready) begin
        if (!w) begin
          if (load_q.size() == 0) check("load_unexpected", req_ready, 0);
          else check("load_data", rdata, load_q.pop_front());
        end
        done = 1;
      end
      tick;
      if (!done) ncyc++;
    end
    check("access_done", done, 1);
    req_valid = 0; req_write = 0; fill_valid = 0; wb_ready = 0;
  endtask

  initial begin
    reset = 1; req_valid = 1; req_write = 0; req_tag = 0; req_index = 0; req_data = 0;
    req_strobe = 0; wb_ready = 0; fill_valid = 0; fill_data = 0;
    tick;
    @(negedge clk);
    check("rst_req_ready_tag0", req_ready, 0);
    check("rst_rdata", rdata, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_fill_req", fill_req, 0);
    check("rst_wb_fields", {wb_tag, wb_word, wb_data}, 0);
    do_reset;

    // Clean write-miss then loads of the refilled and stored words
    push_fill(1, 2, 3, 4);
    access(1, 'h12, 4, 'hDEADBEEF, 'hF, 0);
    check("s1_fill_beats", nfill, 4);
    check("s1_no_wb", nwb, 0);
    check("s1_miss_latency", ncyc, 5);
    load_q.push_back('hDEADBEEF);
    access(0, 'h12, 4, 0, 0, 0);
    check("s1_hit_latency", ncyc, 0);
    load_q.push_back(1);
    access(0, 'h12, 0, 0, 0, 0);
    load_q.push_back(4);
    access(0, 'h12, 12, 0, 0, 0);

    // Partial-strobe merge
    access(1, 'h12, 8, 'h11223344, 'hF, 0);
    access(1, 'h12, 8, 'hAABBCCDD, 4'b0101, 0);
    load_q.push_back('h11BB33DD);
    access(0, 'h12, 8, 0, 0, 0);

    // LRU: touching 0x1 leaves 0x2 as victim
    do_reset;
    push_fill('h10, 'h11, 'h12, 'h13);
    access(1, 'h1, 0, 'hA1, 'hF, 0);
    push_fill('h20, 'h21, 'h22, 'h23);
    access(1, 'h2, 0, 'hA2, 'hF, 0);
    load_q.push_back('hA1);
    access(0, 'h1, 0, 0, 0, 0);
    push_wb('h2, 'hA2, 'h21, 'h22, 'h23);
    push_fill('h30, 'h31, 'h32, 'h33);
    load_q.push_back('h31);
    access(0, 'h3, 4, 0, 0, 0);
    check("s3_wb_beats", nwb, 4);
    check("s3_dirty_latency", ncyc, 9);
    load_q.push_back('hA1);
    access(0, 'h1, 0, 0, 0, 0);
    check("s3_keep_hit", ncyc, 0);

    // Dirty victim with wb_ready stalled 3 cycles per beat
    do_reset;
    push_fill('h50, 'h51, 'h52, 'h53);
    access(1, 'h5, 4, 'h55, 'hF, 0);
    push_fill('h60, 'h61, 'h62, 'h63);
    load_q.push_back('h60);
    access(0, 'h6, 0, 0, 0, 0);
    push_wb('h5, 'h50, 'h55, 'h52, 'h53);
    push_fill('h70, 'h71, 'h72, 'h73);
    load_q.push_back('h72);
    access(0, 'h7, 8, 0, 0, 3);
    check("s4_wb_beats", nwb, 4);
    check("s4_fill_beats", nfill, 4);
    check("s4_stall_latency", ncyc, 21);
    load_q.push_back('h60);
    access(0, 'h6, 0, 0, 0, 0);

    // Reset during refill beat 2 aborts without a valid partial line
    do_reset;
    push_fill('h80, 'h81, 'h82, 'h83);
    req_valid = 1; req_write = 0; req_tag = 'h8; req_index = 0;
    @(negedge clk);
    check("s5_miss", req_ready, 0);
    tick;
    for (int b = 0; b < 3; b++) begin
      fill_valid = 1;
      fill_data = fill_src.pop_front();
      reset = b == 2;
      @(negedge clk);
      check("s5_fill_req", fill_req, 1);
      tick;
    end
    reset = 0;
    fill_valid = 0;
    @(negedge clk);
    check("s5_req_ready", req_ready, 0);
    check("s5_rdata", rdata, 0);
    check("s5_fill_req_off", fill_req, 0);
    check("s5_wb", {wb_valid, wb_tag, wb_word, wb_data}, 0);
    do_reset;

    // LRU across a wrap of the 4-bit age counter
    push_fill('hA0, 'hA1, 'hA2, 'hA3);
    access(1, 'hA, 0, 'hAA, 'hF, 0);
    idle(20);
    push_fill('hB0, 'hB1, 'hB2, 'hB3);
    access(1, 'hB, 0, 'hBB, 'hF, 0);
    idle(3);
    load_q.push_back('hAA);
    access(0, 'hA, 0, 0, 0, 0);
    idle(2);
    push_wb('hB, 'hBB, 'hB1, 'hB2, 'hB3);
    push_fill('hC0, 'hC1, 'hC2, 'hC3);
    load_q.push_back('hC1);
    access(0, 'hC, 4, 0, 0, 0);
    check("s6_wb_beats", nwb, 4);
    load_q.push_back('hAA);
    access(0, 'hA, 0, 0, 0, 0);
    check("s6_keep_hit", ncyc, 0);

    check("queues_empty", load_q.size() + wb_q.size() + fill_src.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_set.md
# cache_set

Parametrised N-way set-associative cache set with byte-strobed writes and true-LRU replacement. It has a built-in miss engine that writes back a dirty victim line word-by-word, then refills the line word-by-word. It sits between the CPU data port and the memory bus adapter; a full cache instantiates one `cache_set` per set index. It supersedes fixed, externally-ticked single lines: age tracking, victim choice and write-back/refill sequencing are internal.

## Interface
- `TAG_WIDTH`, default 20: tag bits per line.
- `LINE_WIDTH`, default 4: log2 of line size in bytes (≥3); `LINE_SIZE = 2**(LINE_WIDTH-2)` words.
- `WAYS`, default 4: associativity (power of two, ≥2).
- `TICK_WIDTH`, default 16: width of the age counter.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  CPU access present.
- `req_write`  in  1  1 = store, 0 = load.
- `req_tag`  in  TAG_WIDTH  address tag.
- `req_index`  in  LINE_WIDTH  byte offset in line; bits [1:0] ignored.
- `req_data`  in  32  store data.
- `req_strobe`  in  4  byte enables for a store.
- `req_ready`  out  1  access completes this cycle.
- `rdata`  out  32  load data; 0 unless `req_ready && !req_write`.
- `wb_valid`  out  1  write-back word valid.
- `wb_ready`  in  1  bus accepts write-back word.
- `wb_tag`  out  TAG_WIDTH  victim tag.
- `wb_word`  out  LINE_WIDTH-2  word index of the write-back word.
- `wb_data`  out  32  write-back data.
- `fill_req`  out  1  refill in progress; fetch line `req_tag`.
- `fill_valid`  in  1  refill word present, delivered in order from word 0.
- `fill_data`  in  32  refill word.

## Operation
- Per way: `valid`, `dirty`, tag, LINE_SIZE data words, TICK_WIDTH last-use stamp. A free-running `now` counter increments every cycle.
- Hit: `req_valid` and some valid way has tag == `req_tag`. At most one way may hit.
- **IDLE**
  - On hit, `req_ready` = 1. A load returns the word combinationally.
  - A store merges `req_data` under `req_strobe` at the clock edge and sets `dirty`.
  - In both cases the hit way's stamp is set to `now`.
  - On miss, `req_ready` = 0 and the victim is latched.
  - Victim choice: the lowest-index invalid way. If all ways are valid, the way with the largest `(now - stamp) mod 2^TICK_WIDTH`; ties go to the lowest index.
  - If the victim is valid and dirty, go to **EVICT**; otherwise go to **FILL**.
- **EVICT**
  - `wb_valid` = 1 and a word counter runs from 0.
  - The counter advances on `wb_valid && wb_ready`.
  - Acceptance of word LINE_SIZE-1 moves the FSM to **FILL**.
- **FILL**
  - `fill_req` = 1 and a word counter runs from 0.
  - Each `fill_valid` writes `fill_data` into the victim at the counter position.
  - On the last word, the victim gets `tag <= req_tag`, `valid <= 1`, `dirty <= 0`, `stamp <= now`, and the FSM returns to **IDLE**.
- The requester holds all `req_*` stable while `req_ready` = 0. After a refill the access replays in IDLE as a hit.
- `req_valid` = 0 in IDLE: no state change except `now`.

## Timing
- Reset values: `req_ready`, `wb_valid`, `fill_req` = 0; `rdata`, `wb_data`, `wb_word`, `wb_tag` = 0. All lines are invalid, clean, with tag 0, stamp 0 and data 0; `now` = 0; FSM in IDLE.
- Hit latency: 0 cycles (combinational `req_ready`/`rdata`). A store is visible to a load in the next cycle.
- Miss, clean victim: FILL starts the cycle after the miss. The hit comes one cycle after the last fill word.
  - Minimum total with a back-to-back fill: LINE_SIZE + 2 cycles.
- Miss, dirty victim: LINE_SIZE accepted wb beats precede FILL.
- `wb_valid` stays high and `wb_data` stays stable while `wb_ready` = 0.
- `fill_valid` outside FILL is ignored.
- Reset mid-EVICT or mid-FILL aborts the sequence immediately. No partial line becomes valid.
- `now` wraps modulo 2^TICK_WIDTH. The age comparison stays correct if every stamp is refreshed within 2^TICK_WIDTH cycles.

## Structure
- `cache_pkg`:
  - `cache_set_state_t` enum {IDLE, EVICT, FILL};
  - a `cache_way_meta_t` struct {valid, dirty, tag, stamp}, parametrised via package localparams defaulting to the widths above.
- Sub-module `cache_way`: storage for one way, with tag match, byte-strobed word write, fill write and metadata update.
  - `cache_set` holds the FSM, the `now` counter, the victim selector and the output muxing.

## Test plan
- WAYS=2, LINE_WIDTH=4 (4 words). Write-miss on tag 0x12, index 4, data 0xDEADBEEF, strobe 4'b1111, fill words 1,2,3,4.
  - Expect `fill_req` for 4 beats, then `req_ready` with no `wb_valid`.
  - A following load at index 4 returns 0xDEADBEEF.
- Store strobe 4'b0101 with data 0xAABBCCDD over 0x11223344 -> load returns 0x11BB33DD.
- Fill tags 0x1 and 0x2; touch 0x1; miss on 0x3 -> the way holding 0x2 is replaced. A later access to 0x1 still hits.
- Dirty victim with `wb_ready` low 3 cycles per beat:
  - 4 beats, `wb_word` 0..3, data stable while stalled;
  - `wb_tag` = victim tag, and FILL starts only after the fourth acceptance.
- Assert reset during FILL beat 2 -> next cycle all outputs 0, and a load to that tag misses.
- Run `now` past wrap (TICK_WIDTH=4, 20 cycles idle between uses) -> LRU still evicts the least-recently-used way.
